blink_sequencer: RTL and testbench

- Playback controller for the LED blinker path of the game.
- On a start pulse from the game FSM, reads the stored colour sequence from pattern memory for entries 0..level-1.
- Lights each colour's LED for a fixed on-time, then holds all LEDs dark for a gap.
- Pulses blinker_done when the whole sequence has been shown; the game FSM then moves to accepting player input.

---
 rtl/blink_sequencer.sv | 138 +++++++++++++
 tb/tb_blink_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_sequencer.sv
// LED playback controller: fetches colours 0..level-1 from pattern memory and blinks each for an on/off period.
// Optional macro BLINK_SPEEDUP_EN halves the on-time (minimum 1) once the latched level reaches 6.
module blink_sequencer #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W      = 26,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        level,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              blinker_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
`ifdef BLINK_SPEEDUP_EN
  localparam int               ON_HALF       = (ON_CYCLES / 2 < 1) ? 1 : ON_CYCLES / 2;
  localparam logic [CNT_W-1:0] ON_LOAD_FAST  = CNT_W'(ON_HALF - 1);
`endif

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [3:0]        lvl_q, lvl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        colour_q, colour_d;

  logic [CNT_W-1:0]  on_load;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   lvl_ext;

  // idx carries one extra bit so that lvl=15 ends on 15 rather than wrapping
  assign idx_inc = idx_q + (ADDR_W+1)'(1);
  assign lvl_ext = (ADDR_W+1)'(lvl_q);

`ifdef BLINK_SPEEDUP_EN
  assign on_load = (lvl_q >= 4'd6) ? ON_LOAD_FAST : ON_LOAD;
`else
  assign on_load = ON_LOAD;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lvl_q    <= '0;
      cnt_q    <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lvl_d    = lvl_q;
    cnt_d    = cnt_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lvl_d   = level;
          idx_d   = '0;
          state_d = (level == 4'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        colour_d = mem_rd_data;
        cnt_d    = on_load;
        state_d  = S_ON;
      end
      S_ON: begin
        if (cnt_q == '0) begin
          cnt_d   = OFF_LOAD;
          state_d = S_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == lvl_ext) ? S_DONE : S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode: outputs depend on registered state only
  always_comb begin
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    led          = 4'b0000;
    busy         = (state_q != S_IDLE);
    blinker_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = idx_q[ADDR_W-1:0];
      end
      S_ON:    led          = 4'b0001 << colour_q;
      S_DONE:  blinker_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer with ON=3/OFF=2: per-cycle expected outputs are queued from the playback timeline
// and popped at each falling edge; table rows cover several levels, hand sequences cover the corner cases.
module tb_blink_sequencer;
  localparam int ON  = 3;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] level;
  logic       mem_rd_en;
  logic [3:0] mem_addr;
  logic [1:0] mem_rd_data = 2'b00;
  logic [3:0] led;
  logic       busy;
  logic       blinker_done;

  always #5 clk = ~clk;

  blink_sequencer #(
    .ON_CYCLES(ON), .OFF_CYCLES(OFF), .CNT_W(8), .ADDR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .level(level),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .led(led), .busy(busy), .blinker_done(blinker_done)
  );

  // pattern memory: read data valid the cycle after the strobe
  logic [1:0] mem [16];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  typedef struct {
    logic [3:0] led;
    logic       rd;
    logic [3:0] addr;
    logic       achk;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int          lvl;
    logic [31:0] pat;
    int          exp_done;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic push_idle(input int n, input logic addr_chk);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{4'b0000, 1'b0, 4'd0, addr_chk, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  // expected outputs for cycles 1..done (or 1..limit) of a playback started at edge 0
  task automatic push_play(input int lvl, input logic [31:0] pat, input int limit, input int idle);
    exp_t       e;
    int         onlen, per, done_c, last, s, o;
    logic [3:0] one;
    one   = 4'b0001;
    onlen = ON;
`ifdef BLINK_SPEEDUP_EN
    if (lvl >= 6) onlen = (ON / 2 < 1) ? 1 : ON / 2;
`endif
    per    = 2 + onlen + OFF;
    done_c = 1 + lvl * per;
    last   = (limit > 0 && limit < done_c) ? limit : done_c;
    for (int c = 1; c <= last; c++) begin
      e = '{4'b0000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
      if (c == done_c) e.done = 1'b1;
      else begin
        s = (c - 1) / per;
        o = (c - 1) % per;
        if (o == 0) begin
          e.rd   = 1'b1;
          e.addr = 4'(s);
          e.achk = 1'b1;
        end else if (o >= 2 && o < 2 + onlen) begin
          e.led = one << pat[2*s +: 2];
        end
      end
      exp_q.push_back(e);
    end
    push_idle(idle, 1'b0);
  endtask

  // pop and compare one record per cycle until the queue drains; repulse/rst_at name a cycle for extra stimulus
  task automatic drain(input string nm, input int repulse, input int rst_at, inout int done_cyc, inout int rd_cnt);
    exp_t e;
    bit   ok;
    int   c;
    c = 1;
    while (exp_q.size() > 0) begin
      if (c == repulse) begin
        start = 1'b1;
        level = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      ok = (led === e.led) && (mem_rd_en === e.rd) && (busy === e.busy) &&
           (blinker_done === e.done) && (!e.achk || mem_addr === e.addr);
      if (!ok) begin
        errors++;
        $display("FAIL %s cycle %0d: got led=%b rd=%b addr=%0d busy=%b done=%b, want led=%b rd=%b addr=%0d busy=%b done=%b",
                 nm, c, led, mem_rd_en, mem_addr, busy, blinker_done, e.led, e.rd, e.addr, e.busy, e.done);
      end
      if (blinker_done === 1'b1) done_cyc = c;
      if (mem_rd_en === 1'b1) rd_cnt++;
      if (c == rst_at) reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      c++;
    end
    start = 1'b0;
  endtask

  task automatic load_mem(input logic [31:0] pat);
    for (int s = 0; s < 16; s++) mem[s] = pat[2*s +: 2];
  endtask

  task automatic fire(input int lvl);
    start = 1'b1;
    level = 4'(lvl);
    @(posedge clk);
    #1;
    start = 1'b0;
    level = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_c, rd_c;
    vecs[0] = '{2, 32'h0000_0006, 15};
    vecs[1] = '{0, 32'h0000_0000, 1};
    vecs[2] = '{1, 32'h0000_0000, 8};
    vecs[3] = '{4, 32'h0000_0093, 29};
`ifdef BLINK_SPEEDUP_EN
    vecs[4] = '{6, 32'h0000_0FFF, 31};
    vecs[5] = '{15, 32'h1B1B_E4E4, 76};
`else
    vecs[4] = '{6, 32'h0000_0FFF, 43};
    vecs[5] = '{15, 32'h1B1B_E4E4, 106};
`endif
    load_mem(32'h0);
    reset = 1'b0;
    start = 1'b1;
    level = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    done_c = -1; rd_c = 0;
    push_idle(1, 1'b1);
    drain("reset_hold", 0, 1, done_c, rd_c);
    push_idle(4, 1'b0);
    drain("reset_idle", 0, 0, done_c, rd_c);
    chk_int("reset_no_done", done_c, -1);
    chk_int("reset_no_read", rd_c, 0);

    foreach (vecs[i]) begin
      load_mem(vecs[i].pat);
      push_play(vecs[i].lvl, vecs[i].pat, 0, 2);
      fire(vecs[i].lvl);
      done_c = -1; rd_c = 0;
      drain($sformatf("vec%0d", i), 0, 0, done_c, rd_c);
      chk_int($sformatf("vec%0d_done_cycle", i), done_c, vecs[i].exp_done);
      chk_int($sformatf("vec%0d_reads", i), rd_c, vecs[i].lvl);
    end

    // start re-pulsed with a different level mid-playback must be ignored
    load_mem(32'h0000_0039);
    push_play(3, 32'h0000_0039, 0, 2);
    fire(3);
    done_c = -1; rd_c = 0;
    drain("busy_start", 5, 0, done_c, rd_c);
    chk_int("busy_start_done_cycle", done_c, 22);
    chk_int("busy_start_reads", rd_c, 3);

    // reset asserted during the first ON phase aborts without a done pulse
    load_mem(32'h0000_0093);
    push_play(4, 32'h0000_0093, 4, 0);
    fire(4);
    done_c = -1; rd_c = 0;
    drain("mid_reset_run", 0, 4, done_c, rd_c);
    push_idle(1, 1'b1);
    push_idle(5, 1'b0);
    drain("mid_reset_after", 0, 0, done_c, rd_c);
    chk_int("mid_reset_no_done", done_c, -1);
    chk_int("mid_reset_reads", rd_c, 1);
    push_play(4, 32'h0000_0093, 0, 2);
    fire(4);
    done_c = -1; rd_c = 0;
    drain("replay", 0, 0, done_c, rd_c);
    chk_int("replay_done_cycle", done_c, 29);
    chk_int("replay_reads", rd_c, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
